// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths and drain FSM state for the systolic array blocks
package systolic_pkg;
  localparam int ACC_W = 32;
  localparam int ACT_W = 8;
  typedef enum logic {IDLE, DRAIN} drain_state_t;
endpackage

// File: rtl/row_mask_next.sv
// row_mask_next: lowest set mask bit strictly above cur, or the lowest set bit overall when from_start
module row_mask_next #(
  parameter int N = 14,
  parameter int W = 4
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] cur,
  input  logic         from_start,
  output logic [W-1:0] nxt,
  output logic         none_above
);
  // scan downward so the lowest qualifying row wins
  always_comb begin
    nxt = '0;
    none_above = 1'b1;
    for (int i = N - 1; i >= 0; i--)
      if (mask[i] && (from_start || W'(i) > cur)) begin
        nxt = W'(i);
        none_above = 1'b0;
      end
  end
endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the PE accumulator grid and streams the enabled rows one beat per cycle
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N_ROWS = 14,
  parameter int N_COLS = 14,
  parameter int ROW_W  = N_ROWS > 1 ? $clog2(N_ROWS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cap_valid,
  output logic                           cap_ready,
  input  logic [N_ROWS-1:0]              cap_row_mask,
  input  logic [N_ROWS*N_COLS*ACC_W-1:0] c_in_flat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_COLS*ACC_W-1:0]        out_data,
  output logic [ROW_W-1:0]               out_row,
  output logic                           out_last,
  output logic                           drain_done,
  output logic                           busy
);
  localparam int NE = N_ROWS * N_COLS;
  drain_state_t state, state_nxt;
  logic [ROW_W-1:0] row_idx, first_idx, adv_idx;
  logic [N_ROWS-1:0] mask_q;
  logic [N_COLS*ACC_W-1:0] shadow [N_ROWS];
  logic none_first, none_above, cap_fire, beat_fire;
  assign cap_fire  = cap_valid && cap_ready;
  assign beat_fire = out_valid && out_ready;
  row_mask_next #(.N(N_ROWS), .W(ROW_W)) u_first (
    .mask(cap_row_mask), .cur('0), .from_start(1'b1), .nxt(first_idx), .none_above(none_first)
  );
  row_mask_next #(.N(N_ROWS), .W(ROW_W)) u_adv (
    .mask(mask_q), .cur(row_idx), .from_start(1'b0), .nxt(adv_idx), .none_above(none_above)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // an empty-mask capture never leaves IDLE; the last accepted beat returns to IDLE
  always_comb
    state_nxt = state == IDLE ? (cap_fire && !none_first ? DRAIN : IDLE)
                              : (beat_fire && out_last ? IDLE : DRAIN);
  // outputs are zeroed whenever no beat is presented
  always_comb begin
    cap_ready = state == IDLE;
    busy      = state != IDLE;
    out_valid = state == DRAIN;
    out_data  = out_valid ? shadow[row_idx] : '0;
    out_row   = row_idx;
    out_last  = out_valid && none_above;
  end
  // shadow capture, row advance and completion pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_idx    <= '0;
      mask_q     <= '0;
      drain_done <= 1'b0;
      for (int r = 0; r < N_ROWS; r++) shadow[r] <= '0;
    end else begin
      drain_done <= (cap_fire && none_first) || (beat_fire && out_last);
      if (cap_fire && !none_first) begin
        mask_q  <= cap_row_mask;
        row_idx <= first_idx;
        for (int r = 0; r < N_ROWS; r++)
          for (int c = 0; c < N_COLS; c++)
            shadow[r][c*ACC_W +: ACC_W] <= c_in_flat[((NE - 1) - (r * N_COLS + c)) * ACC_W +: ACC_W];
      end else if (beat_fire && !out_last) row_idx <= adv_idx;
    end
endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 Parameter N_ROWS, default 14: accumulator rows in the attached PE grid.
REQ-002 Parameter N_COLS, default 14: accumulator columns in the attached PE grid.
REQ-003 Parameter ROW_W, default $clog2(N_ROWS) (min 1): width of the row index output.
REQ-004 clk  input  1: single clock; all state SHALL be on its rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 cap_valid  input  1: the producer offers an accumulator snapshot.
REQ-007 cap_ready  output  1: the block can accept a snapshot.
REQ-008 cap_row_mask  input  N_ROWS: rows to emit; bit r=1 means emit row r.
REQ-009 c_in_flat  input  N_ROWS*N_COLS*32: grid accumulators in stream-packed order.
REQ-010 out_valid  output  1: out_data holds a valid row beat.
REQ-011 out_ready  input  1: the consumer accepts the beat.
REQ-012 out_data  output  N_COLS*32: one row, column c at bits [c*32 +: 32].
REQ-013 out_row  output  ROW_W: grid row index of the current beat.
REQ-014 out_last  output  1: the current beat is the last enabled row of the snapshot.
REQ-015 drain_done  output  1: one-cycle pulse when a snapshot has been fully drained.
REQ-016 busy  output  1: high whenever the state is not IDLE.

Function
REQ-017 Element (r,c) SHALL be read from c_in_flat bits [((N_ROWS*N_COLS-1)-(r*N_COLS+c))*32 +: 32], so element (0,0) occupies the MSBs.
REQ-018 FSM states SHALL be IDLE and DRAIN; cap_ready = (state==IDLE).
REQ-019 Capture handshake: on cap_valid&&cap_ready with a nonzero mask, the block SHALL latch all elements and the mask into shadow registers, set row_idx to the lowest set mask bit, and go to DRAIN.
REQ-020 Capture with mask==0: the block SHALL latch nothing, stay in IDLE, and pulse drain_done the next cycle.
REQ-021 DRAIN: out_valid=1, out_data = shadow row row_idx, out_row = row_idx, out_last = (no set mask bit above row_idx).
REQ-022 While out_valid&&!out_ready, out_data, out_row and out_last SHALL hold stable.
REQ-023 On out_valid&&out_ready&&!out_last, row_idx SHALL advance to the next set mask bit, skipping cleared rows with no bubble cycle.
REQ-024 On out_valid&&out_ready&&out_last, the block SHALL go to IDLE and pulse drain_done the following cycle.
REQ-025 Throughput: one beat per cycle under continuous out_ready; latency from capture to first out_valid is 1 cycle.
REQ-026 cap_valid in DRAIN SHALL be ignored (cap_ready=0); the shadow is not overwritten.
REQ-027 Data SHALL pass through unmodified: no saturation, sign change, or truncation of the 32-bit values.
REQ-028 out_data SHALL be 0 and out_last 0 whenever out_valid=0.

Reset
REQ-029 Asserting rst_n low SHALL immediately force: state IDLE, row_idx 0, mask 0, shadow 0, out_valid 0, out_last 0, drain_done 0, busy 0, cap_ready 1 after release.
REQ-030 Reset during DRAIN SHALL abandon the snapshot; no drain_done is produced for it.

Structure
REQ-031 ACC_W=32, ACT_W=8, and the drain FSM state enum SHALL live in shared package systolic_pkg.
REQ-032 Next-enabled-row search SHALL be a sub-module row_mask_next (inputs: mask, current index; outputs: next index, none_above flag), used both for the initial index (search from -1) and for advancing.

Verification
REQ-033 N_ROWS=N_COLS=4, all-ones mask, element (r,c)=r*16+c, out_ready=1 -> 4 consecutive beats, rows 0..3, beat 2 out_data[1*32+:32]=33, out_last only on row 3, drain_done one cycle after that beat.
REQ-034 Mask 4'b1010 -> exactly 2 beats, out_row 1 then 3, out_last on row 3, no bubble between them.
REQ-035 out_ready held low for 5 cycles on beat 0 -> out_data/out_row stable for all 5 cycles, then the sequence resumes unchanged.
REQ-036 Mask 0 -> no out_valid, drain_done pulses 1 cycle after the handshake, and cap_ready stays 1.
REQ-037 cap_valid pulsed with new data mid-drain -> ignored; the remaining beats carry the original snapshot values.
REQ-038 rst_n low during beat 1 -> out_valid=0 and busy=0 immediately, no drain_done, and a new capture works normally afterwards.
